// File: rtl/food_gen_if.sv
// Food generator handshake: new-food request, candidate occupancy query and placed-food outputs.
// The master modport is the generator; the slave modport is the game/snake-body side.
interface food_gen_if #(
   parameter int X_W = 4,
   parameter int Y_W = 4
);
   logic           eaten;
   logic           occ_hit;
   logic           cand_valid;
   logic [X_W-1:0] cand_x;
   logic [Y_W-1:0] cand_y;
   logic [X_W-1:0] dout_x;
   logic [Y_W-1:0] dout_y;
   logic           food_valid;
   logic           busy;
   logic           board_full;

   modport master (
      input  eaten, occ_hit,
      output cand_valid, cand_x, cand_y, dout_x, dout_y, food_valid, busy, board_full
   );

   modport slave (
      output eaten, occ_hit,
      input  cand_valid, cand_x, cand_y, dout_x, dout_y, food_valid, busy, board_full
   );
endinterface

// File: rtl/food_gen.sv
// Food placement: LFSR draws checked against board bounds and snake occupancy, then a row-major scan fallback.
// Best case food_valid two edges after eaten; eaten is ignored while busy (no queueing).
module food_gen #(
   parameter int          X_W       = 4,
   parameter int          Y_W       = 4,
   parameter int          COLS      = 16,
   parameter int          ROWS      = 16,
   parameter logic [15:0] SEED      = 16'hACE1,
   parameter int          INIT_X    = 11,
   parameter int          INIT_Y    = 2,
   parameter int          MAX_TRIES = 15
) (
   input  logic       clk_out,
   input  logic       rst_n,
   food_gen_if.master bus
);

   typedef enum logic [2:0] {IDLE, GEN, CHECK, SCAN, FULL} state_t;

   localparam logic [X_W:0]   COLS_EXT = (X_W+1)'(COLS);
   localparam logic [Y_W:0]   ROWS_EXT = (Y_W+1)'(ROWS);
   localparam logic [X_W-1:0] LAST_X   = X_W'(COLS - 1);
   localparam logic [Y_W-1:0] LAST_Y   = Y_W'(ROWS - 1);
   localparam logic [7:0]     MAX_T    = 8'(MAX_TRIES);

   state_t         state_q, state_d;
   logic [15:0]    lfsr_q, lfsr_d, lfsr_step;
   logic [7:0]     tries_q, tries_d, tries_inc;
   logic [X_W-1:0] cand_x_q, cand_x_d, dout_x_q, dout_x_d, rnd_x;
   logic [Y_W-1:0] cand_y_q, cand_y_d, dout_y_q, dout_y_d, rnd_y;
   logic           food_valid_q, food_valid_d;
   logic           board_full_q, board_full_d;
   logic           cand_valid;
   logic           rnd_ok;

   assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
   assign rnd_x     = lfsr_step[X_W-1:0];
   assign rnd_y     = lfsr_step[X_W+Y_W-1:X_W];
   assign rnd_ok    = ({1'b0, rnd_x} < COLS_EXT) && ({1'b0, rnd_y} < ROWS_EXT);
   assign tries_inc = tries_q + 8'd1;

   always_comb begin
      state_d      = state_q;
      lfsr_d       = lfsr_q;
      tries_d      = tries_q;
      cand_x_d     = cand_x_q;
      cand_y_d     = cand_y_q;
      dout_x_d     = dout_x_q;
      dout_y_d     = dout_y_q;
      food_valid_d = food_valid_q;
      board_full_d = board_full_q;
      cand_valid   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.eaten) begin
               state_d      = GEN;
               food_valid_d = 1'b0;
               tries_d      = 8'd0;
               board_full_d = 1'b0;
            end
         end
         GEN: begin
            lfsr_d   = lfsr_step;
            tries_d  = tries_inc;
            cand_x_d = rnd_x;
            cand_y_d = rnd_y;
            if (rnd_ok) begin
               state_d = CHECK;
            end else if (tries_inc >= MAX_T) begin
               // Scan begins at the origin, so the candidate register doubles as scan position
               state_d  = SCAN;
               cand_x_d = '0;
               cand_y_d = '0;
            end
         end
         CHECK: begin
            cand_valid = 1'b1;
            if (!bus.occ_hit) begin
               state_d      = IDLE;
               dout_x_d     = cand_x_q;
               dout_y_d     = cand_y_q;
               food_valid_d = 1'b1;
            end else if (tries_q < MAX_T) begin
               state_d = GEN;
            end else begin
               state_d  = SCAN;
               cand_x_d = '0;
               cand_y_d = '0;
            end
         end
         SCAN: begin
            cand_valid = 1'b1;
            if (!bus.occ_hit) begin
               state_d      = IDLE;
               dout_x_d     = cand_x_q;
               dout_y_d     = cand_y_q;
               food_valid_d = 1'b1;
            end else if (cand_x_q == LAST_X) begin
               if (cand_y_q == LAST_Y) begin
                  state_d      = FULL;
                  board_full_d = 1'b1;
               end else begin
                  cand_x_d = '0;
                  cand_y_d = cand_y_q + 1'b1;
               end
            end else begin
               cand_x_d = cand_x_q + 1'b1;
            end
         end
         FULL: begin
            if (bus.eaten) begin
               state_d      = GEN;
               board_full_d = 1'b0;
               tries_d      = 8'd0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_out or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         lfsr_q       <= SEED;
         tries_q      <= 8'd0;
         cand_x_q     <= '0;
         cand_y_q     <= '0;
         dout_x_q     <= X_W'(INIT_X);
         dout_y_q     <= Y_W'(INIT_Y);
         food_valid_q <= 1'b1;
         board_full_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         lfsr_q       <= lfsr_d;
         tries_q      <= tries_d;
         cand_x_q     <= cand_x_d;
         cand_y_q     <= cand_y_d;
         dout_x_q     <= dout_x_d;
         dout_y_q     <= dout_y_d;
         food_valid_q <= food_valid_d;
         board_full_q <= board_full_d;
      end
   end

   assign bus.cand_valid = cand_valid;
   assign bus.cand_x     = cand_x_q;
   assign bus.cand_y     = cand_y_q;
   assign bus.dout_x     = dout_x_q;
   assign bus.dout_y     = dout_y_q;
   assign bus.food_valid = food_valid_q;
   assign bus.board_full = board_full_q;
   assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_food_gen.sv
// Directed bench for food_gen: default board plus an 8-column board to exercise off-board rejection.
module tb_food_gen;

   logic clk_out = 1'b0;
   logic rst_n   = 1'b0;
   int   n_cmp   = 0;
   int   n_err   = 0;

   // Occupancy model: blocked cell (or, with occ_all, every cell except that one)
   logic       occ_all = 1'b0;
   logic       blk_en  = 1'b0;
   logic [3:0] blk_x   = 4'd0;
   logic [3:0] blk_y   = 4'd0;
   logic       m0;

   food_gen_if #(.X_W(4), .Y_W(4)) bus0 ();
   food_gen_if #(.X_W(4), .Y_W(4)) bus1 ();

   food_gen dut0 (.clk_out(clk_out), .rst_n(rst_n), .bus(bus0));
   food_gen #(.COLS(8)) dut1 (.clk_out(clk_out), .rst_n(rst_n), .bus(bus1));

   always #5 clk_out = ~clk_out;

   assign m0           = blk_en && (bus0.cand_x == blk_x) && (bus0.cand_y == blk_y);
   assign bus0.occ_hit = occ_all ? !m0 : m0;
   assign bus1.occ_hit = 1'b0;

   task automatic step();
      @(posedge clk_out);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_dx"}, bus0.dout_x, 11);
      chk({tag, "_dy"}, bus0.dout_y, 2);
      chk({tag, "_fv"}, bus0.food_valid, 1);
      chk({tag, "_busy"}, bus0.busy, 0);
      chk({tag, "_bf"}, bus0.board_full, 0);
      chk({tag, "_cv"}, bus0.cand_valid, 0);
      chk({tag, "_cx"}, bus0.cand_x, 0);
      chk({tag, "_cy"}, bus0.cand_y, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cnt;
      int cv_cnt;

      bus0.eaten = 1'b0;
      bus1.eaten = 1'b0;
      #12;
      rst_n = 1'b1;
      step();
      chk_reset_vals("rst");

      // 8-column board: first draw (0,7) fits, then three off-board draws before (7,2)
      bus1.eaten = 1'b1; step(); bus1.eaten = 1'b0;
      step();
      chk("c8_cv1", bus1.cand_valid, 1);
      chk("c8_c1", {bus1.cand_x, bus1.cand_y}, {4'd0, 4'd7});
      step();
      chk("c8_d1", {bus1.dout_x, bus1.dout_y}, {4'd0, 4'd7});
      bus1.eaten = 1'b1; step(); bus1.eaten = 1'b0;
      step();
      chk("c8_c2", {bus1.cand_x, bus1.cand_y, bus1.cand_valid}, {4'd8, 4'd3, 1'b0});
      step();
      chk("c8_c3", {bus1.cand_x, bus1.cand_y, bus1.cand_valid}, {4'd12, 4'd9, 1'b0});
      step();
      chk("c8_c4", {bus1.cand_x, bus1.cand_y, bus1.cand_valid}, {4'd14, 4'd4, 1'b0});
      step();
      chk("c8_c5", {bus1.cand_x, bus1.cand_y, bus1.cand_valid}, {4'd7, 4'd2, 1'b1});
      step();
      chk("c8_d2", {bus1.dout_x, bus1.dout_y, bus1.food_valid}, {4'd7, 4'd2, 1'b1});

      // Default board, free cells: minimum latency placement
      bus0.eaten = 1'b1; step(); bus0.eaten = 1'b0;
      chk("e0_busy", bus0.busy, 1);
      chk("e0_fv", bus0.food_valid, 0);
      chk("e0_cv", bus0.cand_valid, 0);
      step();
      chk("e1_cv", bus0.cand_valid, 1);
      chk("e1_cand", {bus0.cand_x, bus0.cand_y}, {4'd0, 4'd7});
      chk("e1_fv", bus0.food_valid, 0);
      step();
      chk("e2_dout", {bus0.dout_x, bus0.dout_y}, {4'd0, 4'd7});
      chk("e2_fv", bus0.food_valid, 1);
      chk("e2_busy", bus0.busy, 0);

      // eaten held into GEN must be ignored
      bus0.eaten = 1'b1; step(); step(); bus0.eaten = 1'b0;
      chk("h_cand", {bus0.cand_x, bus0.cand_y, bus0.cand_valid}, {4'd8, 4'd3, 1'b1});
      step();
      chk("h_dout", {bus0.dout_x, bus0.dout_y, bus0.food_valid}, {4'd8, 4'd3, 1'b1});
      step();
      chk("h_idle", bus0.busy, 0);

      // First candidate occupied, second accepted
      do_reset();
      blk_en = 1'b1; blk_x = 4'd0; blk_y = 4'd7;
      bus0.eaten = 1'b1; step(); bus0.eaten = 1'b0;
      cnt = 0;
      while (bus0.busy && cnt < 50) begin cnt++; step(); end
      chk("rej_busy", cnt, 4);
      chk("rej_dout", {bus0.dout_x, bus0.dout_y, bus0.food_valid}, {4'd8, 4'd3, 1'b1});

      // Everything occupied except (3,0): 15 rejected draws, then scan to (3,0)
      do_reset();
      occ_all = 1'b1; blk_x = 4'd3; blk_y = 4'd0;
      bus0.eaten = 1'b1; step(); bus0.eaten = 1'b0;
      cnt = 0; cv_cnt = 0;
      while (bus0.busy && cnt < 200) begin
         if (bus0.cand_valid) cv_cnt++;
         cnt++;
         step();
      end
      chk("scan_busy", cnt, 34);
      chk("scan_cv", cv_cnt, 19);
      chk("scan_dout", {bus0.dout_x, bus0.dout_y, bus0.food_valid}, {4'd3, 4'd0, 1'b1});
      chk("scan_bf", bus0.board_full, 0);

      // Fully occupied board
      do_reset();
      blk_en = 1'b0;
      bus0.eaten = 1'b1; step(); bus0.eaten = 1'b0;
      cnt = 0;
      while (!bus0.board_full && cnt < 600) begin step(); cnt++; end
      chk("full_cyc", cnt, 286);
      chk("full_bf", bus0.board_full, 1);
      chk("full_fv", bus0.food_valid, 0);
      chk("full_busy", bus0.busy, 1);
      chk("full_dout", {bus0.dout_x, bus0.dout_y}, {4'd11, 4'd2});
      step();
      chk("full_hold", {bus0.board_full, bus0.cand_valid}, {1'b1, 1'b0});
      bus0.eaten = 1'b1; step(); bus0.eaten = 1'b0;
      chk("retry_bf", bus0.board_full, 0);
      chk("retry_busy", bus0.busy, 1);
      chk("retry_cv0", bus0.cand_valid, 0);
      step();
      chk("retry_cand", {bus0.cand_x, bus0.cand_y, bus0.cand_valid}, {4'd2, 4'd6, 1'b1});

      // Asynchronous reset while in CHECK
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("arst");
      #2;
      rst_n = 1'b1;
      occ_all = 1'b0;
      bus0.eaten = 1'b1; step(); bus0.eaten = 1'b0;
      step();
      chk("reseed_cand", {bus0.cand_x, bus0.cand_y}, {4'd0, 4'd7});
      step();
      chk("reseed_dout", {bus0.dout_x, bus0.dout_y, bus0.food_valid}, {4'd0, 4'd7, 1'b1});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/food_gen.md
Name: food_gen

Overview:
Parametrised food-position generator for the snake LED-matrix game, replacing the fixed 9-entry lookup scheme. On each `eaten` pulse it draws pseudo-random (x,y) candidates from a 16-bit LFSR and rejects any that fall off the board. It then asks the snake-body logic whether each remaining cell is occupied and rejects occupied cells. After MAX_TRIES failed draws it falls back to a deterministic row-major scan, and flags a full board.

Parameters:
X_W, 4, width of x coordinate (bits)
Y_W, 4, width of y coordinate (bits)
COLS, 16, board columns; valid x is 0..COLS-1 (COLS <= 2**X_W)
ROWS, 16, board rows; valid y is 0..ROWS-1 (ROWS <= 2**Y_W)
SEED, 16'hACE1, LFSR reset value; must be non-zero
INIT_X, 11, food x after reset
INIT_Y, 2, food y after reset
MAX_TRIES, 15, random draws before fallback scan (1..255)

Ports:
clk_out  in  1  system clock
rst_n  in  1  asynchronous active-low reset
eaten  in  1  request for a new food position, sampled on clk_out
occ_hit  in  1  combinational reply from snake-body logic: cell cand_x,cand_y occupied; valid while cand_valid=1
cand_valid  out  1  candidate query strobe
cand_x  out  X_W  candidate column
cand_y  out  Y_W  candidate row
dout_x  out  X_W  current food column
dout_y  out  Y_W  current food row
food_valid  out  1  dout_x/dout_y hold a placed food
busy  out  1  generation in progress (state != IDLE)
board_full  out  1  scan found no free cell

Behaviour:
- Reset values: dout_x=INIT_X, dout_y=INIT_Y, food_valid=1, board_full=0, cand_valid=0, cand_x=0, cand_y=0, state=IDLE, lfsr=SEED, try count=0, scan position=(0,0).
- LFSR: Galois, right shift. next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0). It steps only in GEN, once per draw.
- Candidate from post-step value: x=lfsr[X_W-1:0], y=lfsr[X_W+Y_W-1:X_W].
- States: IDLE, GEN, CHECK, SCAN, FULL.
- IDLE:
  - eaten=1 -> GEN; food_valid<=0, tries<=0, board_full<=0.
  - eaten=0 -> hold.
- GEN:
  - Step the LFSR, latch cand_x/cand_y, tries<=tries+1.
  - Candidate in range (x<COLS and y<ROWS) -> CHECK.
  - Candidate out of range -> remain in GEN if tries+1<MAX_TRIES; otherwise go to SCAN with scan=(0,0).
- CHECK:
  - cand_valid=1 (combinational from state); occ_hit sampled this cycle.
  - occ_hit=0 -> dout<=cand, food_valid<=1, IDLE.
  - occ_hit=1 -> GEN if tries<MAX_TRIES, else SCAN with scan=(0,0).
- SCAN:
  - cand = scan position, cand_valid=1, one cell per cycle in row-major order (x increments, wraps to 0 at COLS-1 with y+1).
  - occ_hit=0 -> dout<=cand, food_valid<=1, IDLE.
  - occ_hit=1 at cell (COLS-1,ROWS-1) -> FULL, board_full<=1.
- FULL: food_valid stays 0. eaten=1 -> clear board_full, tries<=0, GEN (retry).
- Minimum latency: eaten sampled at edge E0, candidate latched at E1, food_valid=1 at E2.
- eaten while busy: ignored; no queueing.
- cand_valid is 0 in IDLE, GEN and FULL. cand_x/cand_y hold their last value.
- Reset mid-operation: immediate return to reset values and abandon the query. The LFSR re-seeds.
- dout_x/dout_y change only on a successful placement or reset.

Test Plan:
- Reset then idle: dout=(11,2), food_valid=1, busy=0, board_full=0, cand_valid=0.
- Default params, occ_hit=0, eaten pulse: LFSR steps 0xACE1->0xE270, cand=(0,7); food_valid=0 for 2 edges; then dout=(0,7), food_valid=1. Second eaten gives lfsr 0x7138, dout=(8,3).
- First CHECK occ_hit=1, then 0: second draw cand=(8,3) is queried; dout=(8,3); busy high for 4 cycles.
- COLS=8: first draw (0,7) is accepted; second draw x=8 is out of range, so GEN repeats with no cand_valid pulse; tries increments; next in-range draw is queried.
- occ_hit tied 1 except cell (3,0), MAX_TRIES=15: 15 rejected draws, then scan (0,0),(1,0),(2,0),(3,0); dout=(3,0), board_full=0.
- occ_hit tied 1: scan covers all 256 cells, then board_full=1, food_valid=0. Next eaten clears board_full and restarts GEN. Assert rst_n low during CHECK: all outputs return to reset values asynchronously.
